interrupt_controller: RTL and testbench
=======================================

Name: interrupt_controller

Overview:
- Arbitrates external interrupt lines and feeds the `interrupt` input of the CPU control FSM.
- Consumes the FSM's `request_interrupt` (FETCH), `vector_to_pc` (SERVICE_INTERRUPT) and `clear_interrupt` (CLRI) outputs.
- Latches the winning source and supplies a stable handler vector to the PC mux.
- Blocks further interrupts until CLRI retires the in-service one; no nesting.

Parameters:
- NUM_IRQ, 8: number of interrupt lines, 1..16.
- VECTOR_BASE, 16'h0100: handler address for line 0.
- VECTOR_SHIFT, 4: log2 of bytes/words between consecutive handler vectors.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- en  in  1  CPU step enable; same signal as the control FSM's `en`.
- irq_in  in  NUM_IRQ  asynchronous interrupt lines, rising-edge triggered.
- request_interrupt  in  1  FSM is in FETCH and will take an interrupt if offered.
- clear_interrupt  in  1  FSM is executing CLRI.
- cfg_wr_en  in  1  write mask/global-enable register.
- cfg_wr_data  in  NUM_IRQ+1  bit NUM_IRQ = global enable; bits NUM_IRQ-1:0 = per-line mask (1 = enabled).
- interrupt  out  1  interrupt offered to the FSM.
- vector  out  16  handler address of the in-service interrupt.
- in_service  out  1  a handler is running.
- active_id  out  4  index of the in-service line.
- pending  out  NUM_IRQ  pending bits, for status readback.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; pending, mask, global_en, synchroniser flops, active_id and vector all 0. All outputs read 0 on the first edge after reset. Reset mid-service drops the in-service interrupt and all pending ones.
- Input path per line: 2-FF synchroniser, then a third flop for edge detect. `rise = s2 & ~s3`.
  - If irq_in goes high before edge k, s1 is set at k, s2 at k+1, and the pending bit at k+2.
  - Level held high generates exactly one pending event.
  - The input path runs regardless of en.
- Eligibility: `elig = pending & mask`, gated by global_en.
- `interrupt = (state==IDLE) & |elig`. This is combinational from registers only; there is no path from request_interrupt, so no combinational loop with the FSM.
- Priority: the lowest eligible index wins. `win_id` is the priority-encoded `elig`.
- State machine:
  - IDLE -> SERVICE when `accept = en & request_interrupt & interrupt`. On accept:
    - active_id <= win_id.
    - vector <= VECTOR_BASE + (win_id << VECTOR_SHIFT), 16-bit, wraps modulo 2^16.
    - pending[win_id] cleared.
  - vector is therefore stable from the cycle SERVICE_INTERRUPT is entered onward.
  - SERVICE -> IDLE on `en & clear_interrupt`. vector and active_id retain their values in IDLE.
  - clear_interrupt in IDLE is ignored. request_interrupt in SERVICE is ignored.
- in_service = (state==SERVICE).
- Simultaneous events:
  - A new rise on win_id in the accept cycle leaves pending[win_id]=1; set beats clear.
  - A rise on any line during SERVICE sets its pending bit; it is offered after CLRI.
  - cfg write and accept in the same cycle: accept uses the old mask; the new mask takes effect next cycle.
  - Clear and a new eligible source in the same cycle: interrupt asserts the following cycle.
- Masking: masked pending bits are retained and are offered once unmasked. Clearing global_en in SERVICE does not abort service.
- en low: accept and clear are suppressed; pending capture and cfg writes still occur.

Decomposition:
- Shared include: state encodings (IDLE=1'b0, SERVICE=1'b1) and the VECTOR_BASE/VECTOR_SHIFT defaults. The CPU top-level uses the same values for its vector table.
- Sub-module `irq_sync_edge`: 1-bit synchroniser plus rise detector, instantiated NUM_IRQ times with a generate loop.
- Priority encoder and FSM stay in the top module.

Test Plan:
- Reset with irq_in=8'hFF -> interrupt=0, pending=0, vector=0. Write cfg 9'h1FF, pulse irq_in[3] -> pending=8'h08 on the 3rd edge and interrupt=1.
- irq_in[5] and irq_in[2] rise together, mask=8'hFF, accept -> active_id=2, vector=16'h0120, pending=8'h20, interrupt=0 until clear_interrupt&en. Next accept -> active_id=5, vector=16'h0150.
- mask=8'h00 with global_en=1, pulse irq_in[0] -> pending=8'h01, interrupt=0. Write mask 8'h01 -> interrupt=1 on the next cycle.
- irq_in[1] re-rises in the accept cycle for line 1 -> pending[1] stays 1. After clear -> interrupt=1, and the second accept yields active_id=1.
- en=0 with request_interrupt=1 and interrupt=1 for 5 cycles -> state stays IDLE, pending unchanged. en=1 -> accept on that cycle.
- Reset asserted during SERVICE with pending=8'h0C -> in_service=0, pending=0, interrupt=0 on the next edge.

Source files
------------

// File: rtl/interrupt_controller_pkg.sv
// -----------------------------------------------------------------------------
// interrupt_controller_pkg
//   Values shared between the interrupt controller and the CPU top level:
//   controller state encodings and the default handler vector table layout.
//   The CPU top level builds its vector table from the same constants, so
//   change them here and nowhere else.
// -----------------------------------------------------------------------------
package interrupt_controller_pkg;

    // Controller state. SERVICE means a handler is running and further
    // interrupts are held off until CLRI retires it.
    typedef enum logic {
        IDLE    = 1'b0,
        SERVICE = 1'b1
    } irq_state_e;

    // Handler address for line 0, and log2 of the spacing between handlers.
    localparam logic [15:0] VECTOR_BASE_DEFAULT  = 16'h0100;
    localparam int          VECTOR_SHIFT_DEFAULT = 4;

endpackage : interrupt_controller_pkg

// File: rtl/irq_sync_edge.sv
// -----------------------------------------------------------------------------
// irq_sync_edge
//   One interrupt line: 2-FF synchroniser followed by a third flop used for
//   rising-edge detection. A level held high yields a single rise pulse.
//
//   Ports
//     clk     in   system clock
//     reset   in   synchronous, active-high reset
//     irq_in  in   asynchronous interrupt line
//     rise    out  one-cycle pulse on a synchronised rising edge
//
//   Timing: irq_in high before edge k sets s1 at k and s2 at k+1; rise is
//   then high for the cycle after k+1, so the consumer captures it at k+2.
// -----------------------------------------------------------------------------
module irq_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic irq_in,
    output logic rise
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic s3_q, s3_d;

    always_comb begin
        s1_d = irq_in;
        s2_d = s1_q;
        s3_d = s2_q;
        rise = s2_q & ~s3_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

endmodule : irq_sync_edge

// File: rtl/interrupt_controller.sv
// -----------------------------------------------------------------------------
// interrupt_controller
//   Arbitrates NUM_IRQ rising-edge interrupt lines for the CPU control FSM.
//   Offers an interrupt while idle, latches the winning line and its handler
//   vector when the FSM takes it in FETCH, and blocks further interrupts
//   until the FSM executes CLRI. No nesting.
//
//   Ports
//     clk                in   system clock
//     reset              in   synchronous, active-high reset
//     en                 in   CPU step enable (same as the FSM's en)
//     irq_in             in   [NUM_IRQ]   asynchronous interrupt lines
//     request_interrupt  in   FSM in FETCH, will take an offered interrupt
//     clear_interrupt    in   FSM executing CLRI
//     cfg_wr_en          in   write mask / global enable
//     cfg_wr_data        in   [NUM_IRQ+1] bit NUM_IRQ = global enable,
//                                         low bits = per-line mask (1 = on)
//     interrupt          out  interrupt offered to the FSM
//     vector             out  [16]        handler address of in-service line
//     in_service         out  a handler is running
//     active_id          out  [4]         index of the in-service line
//     pending            out  [NUM_IRQ]   pending bits, status readback
// -----------------------------------------------------------------------------
module interrupt_controller
    import interrupt_controller_pkg::*;
#(
    parameter int          NUM_IRQ      = 8,
    parameter logic [15:0] VECTOR_BASE  = VECTOR_BASE_DEFAULT,
    parameter int          VECTOR_SHIFT = VECTOR_SHIFT_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               request_interrupt,
    input  logic               clear_interrupt,
    input  logic               cfg_wr_en,
    input  logic [NUM_IRQ:0]   cfg_wr_data,
    output logic               interrupt,
    output logic [15:0]        vector,
    output logic               in_service,
    output logic [3:0]         active_id,
    output logic [NUM_IRQ-1:0] pending
);

    irq_state_e         state_q, state_d;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] mask_q, mask_d;
    logic               global_en_q, global_en_d;
    logic [3:0]         active_id_q, active_id_d;
    logic [15:0]        vector_q, vector_d;

    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] elig;
    logic [NUM_IRQ-1:0] clr_vec;
    logic [3:0]         win_id;
    logic [15:0]        win_vector;
    logic               accept;
    logic               retire;

    // Input path: one synchroniser/edge detector per line, free-running
    // regardless of en.
    for (genvar g = 0; g < NUM_IRQ; g++) begin : g_line
        irq_sync_edge u_sync (
            .clk    (clk),
            .reset  (reset),
            .irq_in (irq_in[g]),
            .rise   (rise[g])
        );
    end

    // Eligibility, offer and lowest-index-wins priority encoder. The offer
    // depends on registers only, so there is no combinational path back from
    // request_interrupt and no loop with the FSM.
    always_comb begin
        // NOTE: every signal written here is assigned a default first, so no
        // path through the block can leave one unassigned and infer a latch.
        elig      = global_en_q ? (pending_q & mask_q) : '0;
        interrupt = (state_q == IDLE) && (|elig);
        win_id    = 4'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (elig[i]) begin
                win_id = 4'(i);
            end
        end
        win_vector = VECTOR_BASE + (16'(win_id) << VECTOR_SHIFT);
        accept     = en & request_interrupt & interrupt;
        retire     = en & clear_interrupt & (state_q == SERVICE);
    end

    // Next-state logic.
    always_comb begin
        state_d     = state_q;
        active_id_d = active_id_q;
        vector_d    = vector_q;
        mask_d      = mask_q;
        global_en_d = global_en_q;
        clr_vec     = '0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d     = SERVICE;
                    active_id_d = win_id;
                    vector_d    = win_vector;
                    for (int i = 0; i < NUM_IRQ; i++) begin
                        clr_vec[i] = (win_id == 4'(i));
                    end
                end
            end
            SERVICE: begin
                // vector and active_id hold their values back into IDLE.
                if (retire) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A rise landing in the accept cycle re-arms the line: set beats clear.
        pending_d = (pending_q & ~clr_vec) | rise;

        // The offer/accept above uses the current mask; a write lands next cycle.
        if (cfg_wr_en) begin
            mask_d      = cfg_wr_data[NUM_IRQ-1:0];
            global_en_d = cfg_wr_data[NUM_IRQ];
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments for all state so every flop samples
        // the pre-edge values, independent of statement order.
        if (reset) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            mask_q      <= '0;
            global_en_q <= 1'b0;
            active_id_q <= 4'd0;
            vector_q    <= 16'd0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            mask_q      <= mask_d;
            global_en_q <= global_en_d;
            active_id_q <= active_id_d;
            vector_q    <= vector_d;
        end
    end

    assign in_service = (state_q == SERVICE);
    assign active_id  = active_id_q;
    assign vector     = vector_q;
    assign pending    = pending_q;

endmodule : interrupt_controller

// File: tb/tb_interrupt_controller.sv
// -----------------------------------------------------------------------------
// tb_interrupt_controller
//   Directed test of interrupt_controller (NUM_IRQ=8, defaults) with
//   hand-computed expected values. Inputs change 1 ns after the rising edge;
//   outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_interrupt_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [7:0]  irq_in;
    logic        request_interrupt;
    logic        clear_interrupt;
    logic        cfg_wr_en;
    logic [8:0]  cfg_wr_data;
    logic        interrupt;
    logic [15:0] vector;
    logic        in_service;
    logic [3:0]  active_id;
    logic [7:0]  pending;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    interrupt_controller #(
        .NUM_IRQ      (8),
        .VECTOR_BASE  (16'h0100),
        .VECTOR_SHIFT (4)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .en                (en),
        .irq_in            (irq_in),
        .request_interrupt (request_interrupt),
        .clear_interrupt   (clear_interrupt),
        .cfg_wr_en         (cfg_wr_en),
        .cfg_wr_data       (cfg_wr_data),
        .interrupt         (interrupt),
        .vector            (vector),
        .in_service        (in_service),
        .active_id         (active_id),
        .pending           (pending)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One-cycle pulse on the selected lines; returns after the edge that
    // captures them into pending.
    task automatic pulse_settle(input logic [7:0] m);
        irq_in = irq_in | m;
        step();
        irq_in = irq_in & ~m;
        step();
        step();
    endtask

    task automatic cfg_write(input logic [8:0] d);
        cfg_wr_en   = 1'b1;
        cfg_wr_data = d;
        step();
        cfg_wr_en   = 1'b0;
    endtask

    task automatic do_clear();
        clear_interrupt = 1'b1;
        step();
        clear_interrupt = 1'b0;
    endtask

    initial begin
        reset = 1'b1; en = 1'b1; irq_in = 8'hFF;
        request_interrupt = 1'b0; clear_interrupt = 1'b0;
        cfg_wr_en = 1'b0; cfg_wr_data = '0;

        // ---- Reset with all lines high
        step();
        step();
        check("rst_interrupt", 32'(interrupt), 32'h0);
        check("rst_pending", 32'(pending), 32'h0);
        check("rst_vector", 32'(vector), 32'h0);
        check("rst_in_service", 32'(in_service), 32'h0);
        check("rst_active_id", 32'(active_id), 32'h0);
        irq_in = 8'h00;
        reset  = 1'b0;
        step();
        step();
        step();
        check("post_rst_pending", 32'(pending), 32'h0);

        // ---- Enable all, pulse line 3: pending on the 3rd edge
        cfg_write(9'h1FF);
        irq_in = 8'h08;
        step();
        irq_in = 8'h00;
        step();
        check("l3_pend_edge2", 32'(pending), 32'h00);
        check("l3_int_edge2", 32'(interrupt), 32'h0);
        step();
        check("l3_pend_edge3", 32'(pending), 32'h08);
        check("l3_int_edge3", 32'(interrupt), 32'h1);
        request_interrupt = 1'b1;
        step();
        request_interrupt = 1'b0;
        check("l3_in_service", 32'(in_service), 32'h1);
        check("l3_active_id", 32'(active_id), 32'h3);
        check("l3_vector", 32'(vector), 32'h0130);
        do_clear();
        check("l3_cleared", 32'(in_service), 32'h0);
        check("l3_vector_kept", 32'(vector), 32'h0130);

        // ---- Lines 5 and 2 together: lowest index first
        pulse_settle(8'h24);
        check("p52_pending", 32'(pending), 32'h24);
        request_interrupt = 1'b1;
        step();
        check("p52_active_id", 32'(active_id), 32'h2);
        check("p52_vector", 32'(vector), 32'h0120);
        check("p52_pending_after", 32'(pending), 32'h20);
        check("p52_int_blocked", 32'(interrupt), 32'h0);
        step();
        check("p52_req_ignored", 32'(active_id), 32'h2);
        request_interrupt = 1'b0;
        en = 1'b0;
        clear_interrupt = 1'b1;
        step();
        check("p52_clr_en0", 32'(in_service), 32'h1);
        en = 1'b1;
        step();
        clear_interrupt = 1'b0;
        check("p52_clr_en1", 32'(in_service), 32'h0);
        check("p52_int_again", 32'(interrupt), 32'h1);
        request_interrupt = 1'b1;
        step();
        request_interrupt = 1'b0;
        check("p52_second_id", 32'(active_id), 32'h5);
        check("p52_second_vec", 32'(vector), 32'h0150);
        do_clear();

        // ---- Masked pending retained, offered once unmasked
        cfg_write(9'h100);
        pulse_settle(8'h01);
        check("mask_pending", 32'(pending), 32'h01);
        check("mask_int", 32'(interrupt), 32'h0);
        cfg_write(9'h101);
        check("unmask_int", 32'(interrupt), 32'h1);
        request_interrupt = 1'b1;
        step();
        request_interrupt = 1'b0;
        check("l0_vector", 32'(vector), 32'h0100);
        do_clear();

        // ---- Re-rise of line 1 in its own accept cycle: set beats clear
        cfg_write(9'h1FF);
        pulse_settle(8'h02);
        check("rr_pending1", 32'(pending), 32'h02);
        irq_in = 8'h02;
        step();
        irq_in = 8'h00;
        step();
        request_interrupt = 1'b1;
        step();
        request_interrupt = 1'b0;
        check("rr_active_id", 32'(active_id), 32'h1);
        check("rr_pending_kept", 32'(pending), 32'h02);
        do_clear();
        check("rr_int_after_clr", 32'(interrupt), 32'h1);
        request_interrupt = 1'b1;
        step();
        request_interrupt = 1'b0;
        check("rr_second_id", 32'(active_id), 32'h1);
        check("rr_pending_empty", 32'(pending), 32'h00);
        do_clear();

        // ---- en low suppresses accept for 5 cycles
        pulse_settle(8'h10);
        en = 1'b0;
        request_interrupt = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("en0_idle", 32'(in_service), 32'h0);
            check("en0_pending", 32'(pending), 32'h10);
        end
        en = 1'b1;
        step();
        request_interrupt = 1'b0;
        check("en1_accept", 32'(in_service), 32'h1);
        check("en1_active_id", 32'(active_id), 32'h4);
        check("en1_vector", 32'(vector), 32'h0140);

        // ---- Reset in service with pending 0C
        pulse_settle(8'h0C);
        check("svc_pending", 32'(pending), 32'h0C);
        check("svc_no_int", 32'(interrupt), 32'h0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_svc_in_service", 32'(in_service), 32'h0);
        check("rst_svc_pending", 32'(pending), 32'h00);
        check("rst_svc_int", 32'(interrupt), 32'h0);
        check("rst_svc_vector", 32'(vector), 32'h0);

        // ---- cfg write and accept together: accept uses the old mask
        cfg_write(9'h1FF);
        pulse_settle(8'h40);
        cfg_wr_en = 1'b1;
        cfg_wr_data = 9'h100;
        request_interrupt = 1'b1;
        step();
        cfg_wr_en = 1'b0;
        request_interrupt = 1'b0;
        check("cfgacc_id", 32'(active_id), 32'h6);
        check("cfgacc_vector", 32'(vector), 32'h0160);
        pulse_settle(8'h80);
        do_clear();
        check("cfgacc_new_mask", 32'(interrupt), 32'h0);
        check("cfgacc_pend_kept", 32'(pending), 32'h80);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_interrupt_controller
